regfile_write_sched: RTL and testbench

- Write-port scheduler for the processor's register bank, which is built from 16-bit two-byte registers, each with its own enable.
- Arbitrates up to NREQ writeback requesters (ALU, load, immediate) onto the single shared write-data bus.
- Drives one-hot per-register enables.
- Provides a hardware clear sequence that zeroes every register, one per cycle.

---
 rtl/regfile_write_sched_pkg.sv | 10 +
 rtl/regfile_write_sched_arbiter.sv | 44 ++++
 rtl/regfile_write_sched.sv | 93 +++++++++
 tb/tb_regfile_write_sched.sv | 122 ++++++++++++
 4 files changed

// File: rtl/regfile_write_sched_pkg.sv
// regfile_write_sched_pkg: shared data width, FSM state encoding and one-hot decode for the write scheduler
package regfile_write_sched_pkg;
  localparam int DW = 16;
  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t CLEAR = 1'b1;
  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/regfile_write_sched_arbiter.sv
// wsched_arbiter: eligibility mask plus fixed-priority or round-robin (WSCHED_RR_ARB_EN) winner pick
module wsched_arbiter #(
  parameter int NREQ = 3,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
`ifdef WSCHED_RR_ARB_EN
  input  logic            clk,
  input  logic            res,
  input  logic            grant_i,
`endif
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] ack_i,
  output logic            win_valid_o,
  output logic [IW-1:0]   win_idx_o
);
  logic [NREQ-1:0] elig;
  // a requester still seeing its ack must not be granted again
  assign elig = req_i & ~ack_i;
`ifdef WSCHED_RR_ARB_EN
  logic [IW-1:0] ptr_q;
  always_comb begin
    win_valid_o = 1'b0;
    win_idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (elig[(int'(ptr_q) + k) % NREQ]) begin
        win_valid_o = 1'b1;
        win_idx_o = IW'((int'(ptr_q) + k) % NREQ);
      end
  end
  always_ff @(posedge clk or negedge res)
    if (!res) ptr_q <= '0;
    else if (grant_i && win_valid_o) ptr_q <= (win_idx_o == IW'(NREQ - 1)) ? '0 : win_idx_o + 1'b1;
`else
  always_comb begin
    win_valid_o = 1'b0;
    win_idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (elig[i]) begin
        win_valid_o = 1'b1;
        win_idx_o = IW'(i);
      end
  end
`endif
endmodule

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: register-bank write-port scheduler with hardware clear sequence.
// Define WSCHED_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module regfile_write_sched
  import regfile_write_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic [NREG-1:0]      reg_en,
  output logic [DW-1:0]        reg_d,
  output logic                 addr_err
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREG-1:0] en_q, en_d;
  logic [DW-1:0]   d_q, d_d;
  logic            busy_q, busy_d, err_q, err_d;
  logic            win_valid, bad, last;
  logic [IW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  wsched_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef WSCHED_RR_ARB_EN
    .clk        (clk),
    .res        (res),
    .grant_i    (state_q == IDLE && !clr_start),
`endif
    .req_i      (req),
    .ack_i      (ack_q),
    .win_valid_o(win_valid),
    .win_idx_o  (win_idx)
  );
  assign win_addr = req_addr[win_idx*AW +: AW];
  assign win_data = req_data[win_idx*DW +: DW];
  assign bad = 32'(win_addr) >= NREG;
  assign last = cnt_q == AW'(NREG - 1);
  // cnt_q is 0 whenever IDLE, so a clear start and every CLEAR step share one path
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = '0;
    en_d = '0;
    d_d = d_q;
    busy_d = 1'b0;
    err_d = 1'b0;
    if (state_q == CLEAR || clr_start) begin
      en_d = NREG'(onehot(5'(cnt_q)));
      d_d = '0;
      busy_d = 1'b1;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      state_d = last ? IDLE : CLEAR;
    end else if (win_valid) begin
      ack_d[win_idx] = 1'b1;
      en_d = bad ? '0 : NREG'(onehot(5'(win_addr)));
      d_d = win_data;
      err_d = bad;
    end
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ack_q <= '0;
      en_q <= '0;
      d_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      en_q <= en_d;
      d_q <= d_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  assign ack = ack_q;
  assign reg_en = en_q;
  assign reg_d = d_q;
  assign clr_busy = busy_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: directed vector table plus clear/reset/address-error sequences
module tb_regfile_write_sched;
  logic        clk = 1'b0, res = 1'b0;
  logic [2:0]  req = '0, ack, req6 = '0, ack6;
  logic [8:0]  req_addr, addr6 = '0;
  logic [47:0] req_data, data6 = '0;
  logic        clr_start = 1'b0, clr_busy, addr_err, clr6 = 1'b0, busy6, err6;
  logic [7:0]  reg_en;
  logic [5:0]  en6;
  logic [15:0] reg_d, d6;
  int checks = 0, failures = 0;
  typedef struct {
    logic [2:0]  req;
    logic [2:0]  ack;
    logic [7:0]  en;
    logic [15:0] d;
  } vec_t;
  vec_t tv[14];
  vec_t w0, w1, w2;
  assign req_addr = {3'd7, 3'd5, 3'd2};
  assign req_data = {16'h2222, 16'h1111, 16'hA5A5};
  always #5 clk = ~clk;
  regfile_write_sched u_dut (
    .clk(clk), .res(res), .req(req), .req_addr(req_addr), .req_data(req_data), .ack(ack),
    .clr_start(clr_start), .clr_busy(clr_busy), .reg_en(reg_en), .reg_d(reg_d), .addr_err(addr_err)
  );
  regfile_write_sched #(.NREG(6)) u_dut6 (
    .clk(clk), .res(res), .req(req6), .req_addr(addr6), .req_data(data6), .ack(ack6),
    .clr_start(clr6), .clr_busy(busy6), .reg_en(en6), .reg_d(d6), .addr_err(err6)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  initial begin
    w0 = '{3'b111, 3'b001, 8'h04, 16'hA5A5};
    w1 = '{3'b111, 3'b010, 8'h20, 16'h1111};
    w2 = '{3'b111, 3'b100, 8'h80, 16'h2222};
    tv[0] = '{3'b001, 3'b001, 8'h04, 16'hA5A5};
    tv[1] = '{3'b000, 3'b000, 8'h00, 16'hA5A5};
    tv[2] = tv[1];
    tv[3] = '{3'b110, 3'b010, 8'h20, 16'h1111};
    tv[4] = '{3'b110, 3'b100, 8'h80, 16'h2222};
    tv[5] = tv[3];
    tv[6] = tv[4];
    tv[7] = w0;
    tv[8] = w1;
`ifdef WSCHED_RR_ARB_EN
    tv[9] = w2; tv[10] = w0; tv[11] = w1; tv[12] = w2;
    tv[13] = '{3'b000, 3'b000, 8'h00, 16'h2222};
`else
    tv[9] = w0; tv[10] = w1; tv[11] = w0; tv[12] = w1;
    tv[13] = '{3'b000, 3'b000, 8'h00, 16'h1111};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0); chk("rst_en", reg_en, 0); chk("rst_d", reg_d, 0);
    chk("rst_busy", clr_busy, 0); chk("rst_err", addr_err, 0); chk("rst_ack6", ack6, 0);
    @(negedge clk) res = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk) req = tv[i].req;
      @(posedge clk) #1;
      chk($sformatf("row%0d_ack", i), ack, tv[i].ack);
      chk($sformatf("row%0d_en", i), reg_en, tv[i].en);
      chk($sformatf("row%0d_d", i), reg_d, tv[i].d);
      chk($sformatf("row%0d_err", i), addr_err, 0);
      chk($sformatf("row%0d_busy", i), clr_busy, 0);
    end
    // clear wins over a pending request; a second clr_start mid-clear is ignored
    @(negedge clk) begin clr_start = 1'b1; req = 3'b001; end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk) #1;
      chk($sformatf("clr%0d_en", k), reg_en, 32'd1 << k);
      chk($sformatf("clr%0d_d", k), reg_d, 0);
      chk($sformatf("clr%0d_busy", k), clr_busy, 1);
      chk($sformatf("clr%0d_ack", k), ack, 0);
      @(negedge clk) clr_start = (k == 2);
    end
    @(posedge clk) #1;
    chk("post_clr_ack", ack, 3'b001); chk("post_clr_en", reg_en, 8'h04);
    chk("post_clr_d", reg_d, 16'hA5A5); chk("post_clr_busy", clr_busy, 0);
    @(negedge clk) req = 3'b000;
    @(posedge clk) #1;
    chk("post_clr_idle_ack", ack, 0);
    // asynchronous reset while the clear is at step 3
    @(negedge clk) clr_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk) #1;
      chk($sformatf("abort%0d_en", k), reg_en, 32'd1 << k);
      @(negedge clk) clr_start = 1'b0;
    end
    #2 res = 1'b0;
    #1;
    chk("async_en", reg_en, 0); chk("async_busy", clr_busy, 0);
    chk("async_d", reg_d, 0); chk("async_ack", ack, 0);
    @(negedge clk) begin res = 1'b1; req = 3'b001; end
    @(posedge clk) #1;
    chk("rel_ack", ack, 3'b001); chk("rel_en", reg_en, 8'h04);
    chk("rel_busy", clr_busy, 0); chk("rel_d", reg_d, 16'hA5A5);
    @(negedge clk) req = 3'b000;
    @(posedge clk) #1;
    chk("rel_idle_en", reg_en, 0);
    chk("rel_no_busy", clr_busy, 0);
    // out-of-range address on a 6-register bank
    @(negedge clk) begin req6 = 3'b010; addr6 = {3'd0, 3'd7, 3'd0}; data6 = {16'h0, 16'hBEEF, 16'h0}; end
    @(posedge clk) #1;
    chk("err_ack", ack6, 3'b010); chk("err_en", en6, 0);
    chk("err_pulse", err6, 1); chk("err_d", d6, 16'hBEEF);
    @(negedge clk) req6 = 3'b000;
    @(posedge clk) #1;
    chk("err_drop", err6, 0); chk("err_ack_drop", ack6, 0);
    @(negedge clk) begin req6 = 3'b010; addr6 = {3'd0, 3'd5, 3'd0}; end
    @(posedge clk) #1;
    chk("top_ack", ack6, 3'b010); chk("top_en", en6, 6'h20); chk("top_err", err6, 0);
    @(negedge clk) req6 = 3'b000;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
